// File: rtl/read_address_sequencer_if.sv
// Handshake bundle between the buffer writer, the read-address sequencer and the consumer.
interface read_address_sequencer_if #(
    parameter int MaxAddress = 20,
    parameter int bitwidth   = 5
);
    logic                wr_valid;
    logic [bitwidth-1:0] wr_address;
    logic                flush;
    logic                rd_ready;
    logic                rd_valid;
    logic [bitwidth-1:0] rd_address;
    logic [bitwidth:0]   fill_level;
    logic                empty;
    logic                full;
    logic                overflow;
    logic                seq_error;

    modport master (
        output wr_valid, wr_address, flush, rd_ready,
        input  rd_valid, rd_address, fill_level, empty, full, overflow, seq_error
    );

    modport slave (
        input  wr_valid, wr_address, flush, rd_ready,
        output rd_valid, rd_address, fill_level, empty, full, overflow, seq_error
    );
endinterface

// File: rtl/read_address_sequencer.sv
// Tracks a sequential write-address stream and replays the same addresses to a
// consumer over valid/ready, with occupancy, status and sticky error flags.
module read_address_sequencer #(
    parameter int MaxAddress = 20,
    parameter int bitwidth   = 5
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    read_address_sequencer_if.slave  bus
);
    localparam logic [bitwidth-1:0] MAX_A = bitwidth'(MaxAddress);
    localparam logic [bitwidth:0]   DEPTH = (bitwidth+1)'(MaxAddress + 1);

    typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_t;

    state_t              state_q;
    logic [bitwidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [bitwidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [bitwidth:0]   count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                seq_err_q, seq_err_d;
    logic                rd_valid_w, rd_fire;

    function automatic logic [bitwidth-1:0] inc(input logic [bitwidth-1:0] p);
        return (p == MAX_A) ? '0 : p + 1'b1;
    endfunction

    // Status decodes come only from the registered state, never from inputs.
    assign rd_valid_w     = (state_q != EMPTY);
    assign rd_fire        = rd_valid_w && bus.rd_ready && !bus.flush;
    assign bus.rd_valid   = rd_valid_w;
    assign bus.empty      = (state_q == EMPTY);
    assign bus.full       = (state_q == FULL);
    assign bus.rd_address = rd_ptr_q;
    assign bus.fill_level = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.seq_error  = seq_err_q;

    always_comb begin
        wr_ptr_d   = bus.wr_valid ? inc(wr_ptr_q) : wr_ptr_q;
        seq_err_d  = seq_err_q | (bus.wr_valid && (bus.wr_address != wr_ptr_q));
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.flush) begin
            // A write in the flush cycle still moves wr_ptr but is dropped.
            count_d  = '0;
            rd_ptr_d = wr_ptr_d;
        end else if (bus.wr_valid && !rd_fire) begin
            if (count_q == DEPTH) begin
                rd_ptr_d   = inc(rd_ptr_q);
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (rd_fire) begin
            rd_ptr_d = inc(rd_ptr_q);
            if (!bus.wr_valid) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q    <= EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            seq_err_q  <= seq_err_d;
            if (bus.flush) begin
                state_q <= EMPTY;
            end else begin
                case (state_q)
                    EMPTY:   if (bus.wr_valid)
                                 state_q <= (count_d == DEPTH) ? FULL : ACTIVE;
                    ACTIVE:  if (count_d == DEPTH)   state_q <= FULL;
                             else if (count_d == '0) state_q <= EMPTY;
                    FULL:    if (rd_fire && !bus.wr_valid)
                                 state_q <= (count_d == '0) ? EMPTY : ACTIVE;
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end
endmodule
